// File: rtl/imm_decode_ctrl_pkg.sv
// Shared definitions for the decode-stage controller: opcode values,
// extension-select encodings, the NOP instruction word and FSM states.
package imm_decode_ctrl_pkg;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_NOP   = 5'b00001;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_LBI   = 5'b11000;

  // Opcode groups identified by their top three bits.
  localparam logic [2:0] OP_BRANCH_PFX = 3'b011;  // BEQZ/BNEZ/BLTZ/BGEZ
  localparam logic [2:0] OP_SHIFT_PFX  = 3'b101;  // ROLI/SLLI/RORI/SRLI

  localparam logic [2:0] SESEL_ZERO5  = 3'd0;
  localparam logic [2:0] SESEL_ZERO8  = 3'd1;
  localparam logic [2:0] SESEL_SIGN5  = 3'd2;
  localparam logic [2:0] SESEL_SIGN8  = 3'd4;
  localparam logic [2:0] SESEL_SIGN11 = 3'd6;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic {
    STATE_RUN    = 1'b0,
    STATE_HALTED = 1'b1
  } state_e;

  function automatic logic [4:0] opcode_of(input logic [15:0] instr);
    return instr[15:11];
  endfunction

endpackage

// File: rtl/imm_decode_ctrl_imm_sel_decode.sv
// Combinational opcode decoder for the immediate extender. Shared with the
// hazard unit.
//   opcode_i  : instruction bits [15:11]
//   sesel_o   : extension select (zero5/zero8/sign5/sign8/sign11)
//   has_imm_o : instruction consumes the extended immediate
module imm_sel_decode
  import imm_decode_ctrl_pkg::*;
(
  input  logic [4:0] opcode_i,
  output logic [2:0] sesel_o,
  output logic       has_imm_o
);

  always_comb begin
    sesel_o   = SESEL_ZERO5;
    has_imm_o = 1'b0;
    if (opcode_i[4:2] == OP_BRANCH_PFX) begin
      sesel_o   = SESEL_SIGN8;
      has_imm_o = 1'b1;
    end else if (opcode_i[4:2] == OP_SHIFT_PFX) begin
      sesel_o   = SESEL_ZERO5;
      has_imm_o = 1'b1;
    end else begin
      case (opcode_i)
        OP_ADDI, OP_SUBI, OP_ST, OP_LD, OP_STU: begin
          sesel_o   = SESEL_SIGN5;
          has_imm_o = 1'b1;
        end
        OP_XORI, OP_ANDNI: begin
          sesel_o   = SESEL_ZERO5;
          has_imm_o = 1'b1;
        end
        OP_LBI, OP_JR, OP_JALR: begin
          sesel_o   = SESEL_SIGN8;
          has_imm_o = 1'b1;
        end
        OP_SLBI: begin
          sesel_o   = SESEL_ZERO8;
          has_imm_o = 1'b1;
        end
        OP_J, OP_JAL: begin
          sesel_o   = SESEL_SIGN11;
          has_imm_o = 1'b1;
        end
        default: begin
          sesel_o   = SESEL_ZERO5;
          has_imm_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_decode_ctrl.sv
// Decode-stage controller between fetch and execute. Holds one instruction in
// the ID/EX register, decodes its immediate format, and handles flush, HALT,
// execute backpressure and fetch handshake checking.
//   clk, rst_n                     : clock, async active-low reset
//   in_valid/in_ready/in_instr/in_pc : fetch handshake
//   flush                          : squash held and incoming instruction
//   out_valid/out_ready/out_*      : ID/EX register towards execute
//   halted                         : HALT accepted, fetch blocked until flush
//   stall_cnt                      : saturating count of backpressured cycles
//   err                            : sticky fetch-protocol violation
//
// state        | meaning
// STATE_RUN    | accepting instructions from fetch
// STATE_HALTED | HALT accepted; fetch blocked until flush
module imm_decode_ctrl
  import imm_decode_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_instr,
  input  logic [15:0]            in_pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_instr,
  output logic [15:0]            out_pc,
  output logic [2:0]             out_sesel,
  output logic                   out_has_imm,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   err
);

  state_e                 state_q, state_d;
  logic                   out_valid_q, out_valid_d;
  logic [15:0]            out_instr_q, out_instr_d;
  logic [15:0]            out_pc_q, out_pc_d;
  logic [2:0]             sesel_q, sesel_d;
  logic                   has_imm_q, has_imm_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   err_q, err_d;
  // Fetch was stalled last cycle; its request must be repeated unchanged.
  logic                   pend_q, pend_d;
  logic [15:0]            req_instr_q, req_pc_q;

  logic [4:0] opcode;
  logic [2:0] dec_sesel;
  logic       dec_has_imm;
  logic       accept;

  assign opcode = opcode_of(in_instr);

  imm_sel_decode u_imm_sel_decode (
    .opcode_i  (opcode),
    .sesel_o   (dec_sesel),
    .has_imm_o (dec_has_imm)
  );

  assign in_ready = (state_q == STATE_RUN) && !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    sesel_d     = sesel_q;
    has_imm_d   = has_imm_q;
    stall_d     = stall_q;
    err_d       = err_q;
    pend_d      = 1'b0;

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = STATE_RUN;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = in_instr;
      out_pc_d    = in_pc;
      sesel_d     = dec_sesel;
      has_imm_d   = dec_has_imm;
      if (opcode == OP_HALT) state_d = STATE_HALTED;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (out_valid_q && !out_ready && !(&stall_q)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end

    // A flush cycle or HALTED never arms the check, so the following cycle
    // is exempt and in_valid is ignored while halted.
    pend_d = in_valid && !in_ready && (state_q == STATE_RUN) && !flush;

    if (pend_q && (!in_valid || (in_instr != req_instr_q) || (in_pc != req_pc_q))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STATE_RUN;
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= 16'h0000;
      sesel_q     <= SESEL_ZERO5;
      has_imm_q   <= 1'b0;
      stall_q     <= '0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      req_instr_q <= 16'h0000;
      req_pc_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      sesel_q     <= sesel_d;
      has_imm_q   <= has_imm_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      req_instr_q <= in_instr;
      req_pc_q    <= in_pc;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign out_sesel   = sesel_q;
  assign out_has_imm = has_imm_q;
  assign halted      = (state_q == STATE_HALTED);
  assign stall_cnt   = stall_q;
  assign err         = err_q;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
module tb_imm_decode_ctrl;
  localparam int W       = 8;
  localparam int SAT_MAX = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_instr = 16'h0;
  logic [15:0]   in_pc = 16'h0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [15:0]   out_instr;
  logic [15:0]   out_pc;
  logic [2:0]    out_sesel;
  logic          out_has_imm;
  logic          halted;
  logic [W-1:0]  stall_cnt;
  logic          err;

  always #5 clk = ~clk;

  imm_decode_ctrl #(.STALL_CNT_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_sesel   (out_sesel),
    .out_has_imm (out_has_imm),
    .halted      (halted),
    .stall_cnt   (stall_cnt),
    .err         (err)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Transaction-level reference: contents of the one-entry register plus
  // the halted/stall/err bookkeeping.
  bit          m_valid, m_halted, m_err, m_pend, m_has;
  logic [15:0] m_instr, m_pc, m_prev_instr, m_prev_pc;
  logic [2:0]  m_sesel;
  int          m_stall;
  logic        last_rdy_obs;

  // {has_imm, sesel} straight from the instruction-set table.
  function automatic logic [3:0] ref_decode(input logic [4:0] op);
    if (op inside {5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011}) return {1'b1, 3'd2};
    if (op inside {5'b01010, 5'b01011, 5'b10100, 5'b10101, 5'b10110, 5'b10111}) return {1'b1, 3'd0};
    if (op inside {5'b01100, 5'b01101, 5'b01110, 5'b01111, 5'b11000, 5'b00101, 5'b00111}) return {1'b1, 3'd4};
    if (op == 5'b10010) return {1'b1, 3'd1};
    if (op inside {5'b00100, 5'b00110}) return {1'b1, 3'd6};
    return 4'b0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".halted"},    32'(halted),    32'(m_halted));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    chk({tag, ".err"},       32'(err),       32'(m_err));
    if (m_valid) begin
      chk({tag, ".out_instr"},   32'(out_instr),   32'(m_instr));
      chk({tag, ".out_pc"},      32'(out_pc),      32'(m_pc));
      chk({tag, ".out_sesel"},   32'(out_sesel),   32'(m_sesel));
      chk({tag, ".out_has_imm"}, 32'(out_has_imm), 32'(m_has));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #1;
    m_valid = 0; m_halted = 0; m_err = 0; m_pend = 0; m_stall = 0;
    chk("rst.out_instr",   32'(out_instr),   32'h0800);
    chk("rst.out_pc",      32'(out_pc),      32'h0);
    chk("rst.out_sesel",   32'(out_sesel),   32'h0);
    chk("rst.out_has_imm", 32'(out_has_imm), 32'h0);
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                      input logic fl, input logic rdy, input string tag);
    bit n_valid, n_halted, n_err, n_pend, exp_rdy, acc;
    int n_stall;
    logic [3:0] d;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = pc; flush = fl; out_ready = rdy;
    #1;
    exp_rdy = !m_halted && !fl && (!m_valid || rdy);
    last_rdy_obs = in_ready;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;

    n_valid = m_valid; n_halted = m_halted; n_err = m_err; n_stall = m_stall;
    if (m_pend && (!v || ins != m_prev_instr || pc != m_prev_pc)) n_err = 1;
    n_pend = v && !exp_rdy && !fl && !m_halted;
    if (m_valid && !rdy && m_stall < SAT_MAX) n_stall = m_stall + 1;
    if (fl) begin
      n_valid = 0; n_halted = 0;
    end else if (acc) begin
      d = ref_decode(ins[15:11]);
      n_valid = 1; m_instr = ins; m_pc = pc; m_sesel = d[2:0]; m_has = d[3];
      if (ins[15:11] == 5'b00000) n_halted = 1;
    end else if (m_valid && rdy) begin
      n_valid = 0;
    end

    @(posedge clk);
    #1;
    m_valid = n_valid; m_halted = n_halted; m_err = n_err; m_pend = n_pend; m_stall = n_stall;
    m_prev_instr = ins; m_prev_pc = pc;
    check_outputs(tag);
  endtask

  initial begin
    bit          have;
    logic [15:0] ri, rp;
    logic        fl, rdy;

    do_reset();

    // Single ADDI
    step(1, 16'h4125, 16'h0102, 0, 1, "addi");
    chk("addi.valid", 32'(out_valid), 32'h1);
    chk("addi.sesel", 32'(out_sesel), 32'h2);
    chk("addi.imm",   32'(out_has_imm), 32'h1);
    chk("addi.pc",    32'(out_pc), 32'h0102);

    // Back-to-back J, SLBI, XORI
    step(1, 16'h2000, 16'h0104, 0, 1, "j");
    chk("j.sesel", 32'(out_sesel), 32'h6);
    step(1, 16'h9000, 16'h0106, 0, 1, "slbi");
    chk("slbi.sesel", 32'(out_sesel), 32'h1);
    step(1, 16'h5000, 16'h0108, 0, 1, "xori");
    chk("xori.sesel", 32'(out_sesel), 32'h0);
    chk("xori.imm",   32'(out_has_imm), 32'h1);

    // Backpressure for 5 cycles with fetch holding its request
    for (int i = 0; i < 5; i++) step(1, 16'h4125, 16'h010A, 0, 0, "bp");
    chk("bp.stall5", 32'(stall_cnt), 32'd5);
    chk("bp.instr",  32'(out_instr), 32'h5000);
    chk("bp.err",    32'(err), 32'h0);
    for (int i = 0; i < 300; i++) step(1, 16'h4125, 16'h010A, 0, 0, "sat");
    chk("sat.stall", 32'(stall_cnt), 32'd255);
    step(1, 16'h4125, 16'h010A, 0, 1, "release");
    step(0, 16'h0000, 16'h0000, 0, 1, "drain");

    // HALT then flush
    step(1, 16'h0000, 16'h0200, 0, 1, "halt");
    chk("halt.halted", 32'(halted), 32'h1);
    step(1, 16'h4125, 16'h0202, 0, 0, "halt_hold");
    chk("halt.in_ready", 32'(last_rdy_obs), 32'h0);
    step(0, 16'h0000, 16'h0000, 1, 0, "flush");
    chk("flush.valid",  32'(out_valid), 32'h0);
    chk("flush.halted", 32'(halted), 32'h0);
    step(0, 16'h0000, 16'h0000, 0, 1, "post_flush");
    chk("post_flush.in_ready", 32'(last_rdy_obs), 32'h1);

    // Flush with an incoming instruction and an empty register
    step(1, 16'h4125, 16'h0300, 1, 1, "flush_in");
    chk("flush_in.valid", 32'(out_valid), 32'h0);
    step(0, 16'h0000, 16'h0000, 0, 1, "flush_in2");
    chk("flush_in.err", 32'(err), 32'h0);

    // Protocol violation: stalled fetch changes its instruction
    step(1, 16'h4001, 16'h0400, 0, 0, "pv_fill");
    step(1, 16'h4002, 16'h0402, 0, 0, "pv_stall");
    step(1, 16'h4003, 16'h0402, 0, 0, "pv_change");
    chk("pv.err", 32'(err), 32'h1);
    step(1, 16'h4003, 16'h0402, 0, 1, "pv_tr1");
    step(1, 16'hC055, 16'h0404, 0, 1, "pv_tr2");
    step(0, 16'h0000, 16'h0000, 0, 1, "pv_tr3");
    chk("pv.err_sticky", 32'(err), 32'h1);
    do_reset();
    chk("pv.err_cleared", 32'(err), 32'h0);

    // Randomized traffic under a protocol-abiding fetch
    have = 0; ri = 16'h0; rp = 16'h0;
    for (int i = 0; i < 400; i++) begin
      if (!have && $urandom_range(3) != 0) begin
        have = 1;
        ri = 16'($urandom);
        rp = 16'($urandom);
        if (ri[15:11] == 5'b00000 && $urandom_range(1) == 1) ri[15:11] = 5'b01000;
      end
      fl  = ($urandom_range(9) == 0);
      rdy = ($urandom_range(2) != 0);
      if (have && !m_halted && !fl && (!m_valid || rdy)) begin
        step(1, ri, rp, fl, rdy, "rnd");
        have = 0;
      end else begin
        step(have, ri, rp, fl, rdy, "rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imm_decode_ctrl.md
Name: imm_decode_ctrl

Overview:
- Decode-stage controller between fetch and execute in the 16-bit pipeline.
- Accepts instructions from fetch over a valid/ready handshake and holds them in a one-entry ID/EX register.
- Decodes the opcode into the 3-bit extension select for the immediate extender and a has-immediate flag.
- Handles flush, halt, downstream backpressure and fetch protocol checking.

Parameters:
- STALL_CNT_W, 8, width of the saturating backpressure-cycle counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  controller can accept this cycle
- in_instr  in  16  instruction word
- in_pc  in  16  PC+2 of the instruction
- flush  in  1  squash held and incoming instruction (branch or exception redirect)
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  execute consumes this cycle
- out_instr  out  16  registered instruction
- out_pc  out  16  registered PC+2
- out_sesel  out  3  extension select: 0 zero5, 1 zero8, 2/3 sign5, 4/5 sign8, 6/7 sign11
- out_has_imm  out  1  instruction uses the extended immediate
- halted  out  1  HALT has been accepted; fetch is blocked
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- err  out  1  sticky fetch-protocol violation

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_instr=16'h0800 (NOP), out_pc=0, out_sesel=0, out_has_imm=0, halted=0, stall_cnt=0, err=0, state RUN. Reset is honoured mid-transfer; in-flight data is lost.
- States:
  - RUN: normal operation.
  - HALTED: entered on the clock edge that accepts opcode 00000. Exited to RUN only by flush.
- in_ready = (state==RUN) && !flush && (!out_valid || out_ready). Combinational; no dependence on in_valid.
- Accept = in_valid && in_ready. On accept, the ID/EX register loads instr, pc and decoded sesel/has_imm, and out_valid=1 next cycle. Latency is 1 cycle from accept to out_valid.
- Consume without accept: when out_valid && out_ready and no accept, out_valid=0 next cycle.
- Simultaneous consume and accept: the register reloads and out_valid stays 1. This gives full throughput, one instruction per cycle.
- Backpressure: out_valid && !out_ready holds all out_* stable.
- Flush has highest priority:
  - out_valid=0 next cycle.
  - No accept that cycle.
  - HALTED returns to RUN.
  - stall_cnt is unaffected.
- Opcode decode on in_instr[15:11]:
  - sign5 (sesel=2): ADDI 01000, SUBI 01001, ST 10000, LD 10001, STU 10011.
  - zero5 (sesel=0): XORI 01010, ANDNI 01011, ROLI/SLLI/RORI/SRLI 101xx.
  - sign8 (sesel=4): BEQZ/BNEZ/BLTZ/BGEZ 011xx, LBI 11000, JR 00101, JALR 00111.
  - zero8 (sesel=1): SLBI 10010.
  - sign11 (sesel=6): J 00100, JAL 00110.
  - All other opcodes: sesel=0, has_imm=0. For every listed opcode, has_imm=1.
- stall_cnt increments each cycle out_valid && !out_ready and saturates at all-ones; there is no wrap.
- err: sets and stays set until reset when, in a cycle after in_valid=1 && in_ready=0, either in_valid drops or in_instr/in_pc changes. Fetch must hold a stalled request stable. A flush cycle exempts the check for the following cycle.
- In HALTED, a pending HALT in the register still drains normally. in_valid is ignored and does not raise err.

Decomposition:
- Shared package: opcode localparams (OP_HALT, OP_NOP, OP_ADDI, ...), SESEL_ZERO5/ZERO8/SIGN5/SIGN8/SIGN11 constants, NOP instruction constant, STATE_RUN/STATE_HALTED encoding.
- One combinational sub-module, imm_sel_decode: opcode[4:0] -> sesel[2:0], has_imm. It is reused by the hazard unit.

Test Plan:
- Reset release, then ADDI 16'h4125 with out_ready=1: out_valid at cycle+1, out_sesel=2, out_has_imm=1, out_pc matches input.
- Back-to-back J 16'h2000, SLBI 16'h9000, XORI 16'h5000 with out_ready=1: one per cycle, sesel 6,1,0; in_ready stays 1.
- out_ready=0 for 5 cycles with valid held: out_* stable, in_ready=0, stall_cnt=5. Force 300 stall cycles: stall_cnt saturates at 255.
- Accept HALT 16'h0000: halted=1 next cycle, in_ready=0. Assert flush: out_valid=0, halted=0, in_ready=1 the cycle after.
- Flush coincident with in_valid=1 and an empty register: no accept, out_valid stays 0, err stays 0.
- Stalled fetch changes in_instr while in_ready=0: err=1 next cycle and stays 1 through later traffic until rst_n=0.
